lsu: RTL

Load/store unit forming the memory stage between `alu` and `wb`. Takes one effective address plus store data per accepted operation and sizes, aligns and sign-extends loads. Reads 512-bit blocks through `memory_controller`, holding the last block in a one-entry line buffer, and issues write-through stores. Delivers load results to `wb`, which drives `ld_or_alu` and `lddata_in` from them.

---
 rtl/lsu_pkg.sv | 55 +++++
 rtl/lsu_load_align.sv | 36 +++
 rtl/lsu.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store unit.
//   lsu_state_t   - FSM state encoding
//   F3_*          - RISC-V funct3 size/sign codes for loads and stores
//   BLK_OFF_BITS  - byte offset width inside a 64-byte block
//   TAG_BITS      - line buffer tag width (address bits above the block offset)
//   size_strobe   - byte-enable pattern for an access size (before lane shift)
//   misaligned    - true when an address offset violates natural alignment
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_WR_WAIT = 2'd2,
    S_DONE    = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  localparam int BLK_OFF_BITS = 6;
  localparam int TAG_BITS     = 58;

  function automatic logic [7:0] size_strobe(input logic [1:0] size);
    logic [7:0] s;
    case (size)
      2'd0:    s = 8'h01;
      2'd1:    s = 8'h03;
      2'd2:    s = 8'h0F;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
    logic m;
    case (size)
      2'd0:    m = 1'b0;
      2'd1:    m = off[0];
      2'd2:    m = |off[1:0];
      default: m = |off;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: combinational load extraction from a 512-bit block.
//   block  - 64-byte memory block
//   off    - byte offset of the access inside the block
//   funct3 - load size/sign code
//   data   - selected, right-aligned and extended 64-bit load value
// The dword is chosen by off[5:3] and shifted down by off[2:0] bytes; an
// illegal funct3 yields zero (the top never uses it for an illegal load).
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [511:0] block,
  input  logic [5:0]   off,
  input  logic [2:0]   funct3,
  output logic [63:0]  data
);

  logic [63:0] dword;
  logic [63:0] shifted;

  always_comb begin
    dword   = block[{off[5:3], 6'b000000} +: 64];
    shifted = dword >> {off[2:0], 3'b000};
    data    = '0;
    case (funct3)
      F3_LB:   data = {{56{shifted[7]}},  shifted[7:0]};
      F3_LH:   data = {{48{shifted[15]}}, shifted[15:0]};
      F3_LW:   data = {{32{shifted[31]}}, shifted[31:0]};
      F3_LD:   data = shifted;
      F3_LBU:  data = {56'd0, shifted[7:0]};
      F3_LHU:  data = {48'd0, shifted[15:0]};
      F3_LWU:  data = {32'd0, shifted[31:0]};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: memory-stage load/store unit with a one-entry 64-byte line buffer.
//   clk, reset                 - clock, asynchronous active-high reset
//   in_valid/in_ready          - operation handshake (ready only in IDLE)
//   in_is_store, in_funct3     - operation kind and size/sign code
//   in_addr, in_wdata, in_rd   - effective address, store data, load destination
//   flush                      - invalidate the line buffer
//   out_valid/out_we/out_rd/out_data/out_err - one-cycle completion to wb
//   mem_req/mem_wr_en/mem_addr/mem_wdata/mem_wstrb - request to memory controller
//   mem_data_in/mem_data_valid - read block and completion acknowledge
//
// state     | meaning
// S_IDLE    | ready to accept an operation
// S_RD_WAIT | load miss, block read outstanding
// S_WR_WAIT | write-through store outstanding
// S_DONE    | out_valid pulse to wb
module lsu
  import lsu_pkg::*;
#(
  parameter int WORDSZ  = 64,
  parameter int BLOCKSZ = 512,
  parameter int REGSZ   = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_is_store,
  input  logic [2:0]         in_funct3,
  input  logic [WORDSZ-1:0]  in_addr,
  input  logic [WORDSZ-1:0]  in_wdata,
  input  logic [REGSZ-1:0]   in_rd,
  input  logic               flush,
  output logic               out_valid,
  output logic               out_we,
  output logic [REGSZ-1:0]   out_rd,
  output logic [WORDSZ-1:0]  out_data,
  output logic               out_err,
  output logic               mem_req,
  output logic               mem_wr_en,
  output logic [WORDSZ-1:0]  mem_addr,
  output logic [WORDSZ-1:0]  mem_wdata,
  output logic [7:0]         mem_wstrb,
  input  logic [BLOCKSZ-1:0] mem_data_in,
  input  logic               mem_data_valid
);

  lsu_state_t state, state_nxt;

  logic [WORDSZ-1:0]   lat_addr;
  logic [2:0]          lat_funct3;

  logic [BLOCKSZ-1:0]  buf_data;
  logic [TAG_BITS-1:0] buf_tag;
  logic                buf_valid;

  logic                accept;
  logic                acc_err;
  logic                buf_hit;
  logic                ld_hit;
  logic                fill;
  logic                mem_done;
  logic [7:0]          st_strb;
  logic [WORDSZ-1:0]   st_wdata;

  logic [BLOCKSZ-1:0]  align_block;
  logic [5:0]          align_off;
  logic [2:0]          align_funct3;
  logic [WORDSZ-1:0]   align_data;

  // Held low while reset is asserted so nothing is offered during reset.
  assign in_ready = (state == S_IDLE) && !reset;
  assign accept   = in_valid && in_ready;

  assign acc_err  = in_is_store ? (in_funct3[2] || misaligned(in_funct3[1:0], in_addr[2:0]))
                                : ((in_funct3 == 3'b111) || misaligned(in_funct3[1:0], in_addr[2:0]));
  assign buf_hit  = buf_valid && (buf_tag == in_addr[WORDSZ-1:BLK_OFF_BITS]);
  // A flush in the accept cycle wins over the stale buffer contents.
  assign ld_hit   = buf_hit && !flush;

  assign st_strb  = size_strobe(in_funct3[1:0]) << in_addr[2:0];
  assign st_wdata = in_wdata << {in_addr[2:0], 3'b000};

  assign mem_done = ((state == S_RD_WAIT) || (state == S_WR_WAIT)) && mem_data_valid;
  assign fill     = (state == S_RD_WAIT) && mem_data_valid;

  // One extractor serves both paths: buffer hit at accept, or the arriving block on fill.
  always_comb begin
    align_block  = buf_data;
    align_off    = in_addr[5:0];
    align_funct3 = in_funct3;
    if (state == S_RD_WAIT) begin
      align_block  = mem_data_in;
      align_off    = lat_addr[5:0];
      align_funct3 = lat_funct3;
    end
  end

  lsu_load_align u_align (
    .block  (align_block),
    .off    (align_off),
    .funct3 (align_funct3),
    .data   (align_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (acc_err)          state_nxt = S_DONE;
          else if (in_is_store) state_nxt = S_WR_WAIT;
          else if (ld_hit)      state_nxt = S_DONE;
          else                  state_nxt = S_RD_WAIT;
        end
      end
      S_RD_WAIT: if (mem_data_valid) state_nxt = S_DONE;
      S_WR_WAIT: if (mem_data_valid) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_addr   <= '0;
      lat_funct3 <= '0;
      out_valid  <= 1'b0;
      out_we     <= 1'b0;
      out_rd     <= '0;
      out_data   <= '0;
      out_err    <= 1'b0;
      mem_req    <= 1'b0;
      mem_wr_en  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
    end else begin
      out_valid <= 1'b0;
      out_we    <= 1'b0;
      out_err   <= 1'b0;
      if (accept) begin
        lat_addr   <= in_addr;
        lat_funct3 <= in_funct3;
        out_rd     <= in_rd;
        if (acc_err) begin
          out_valid <= 1'b1;
          out_err   <= 1'b1;
          out_data  <= '0;
        end else if (in_is_store) begin
          mem_req   <= 1'b1;
          mem_wr_en <= 1'b1;
          mem_addr  <= {in_addr[WORDSZ-1:3], 3'b000};
          mem_wdata <= st_wdata;
          mem_wstrb <= st_strb;
        end else if (ld_hit) begin
          out_valid <= 1'b1;
          out_we    <= 1'b1;
          out_data  <= align_data;
        end else begin
          mem_req   <= 1'b1;
          mem_wr_en <= 1'b0;
          mem_addr  <= {in_addr[WORDSZ-1:BLK_OFF_BITS], {BLK_OFF_BITS{1'b0}}};
        end
      end
      if (mem_done) begin
        mem_req   <= 1'b0;
        mem_wr_en <= 1'b0;
        out_valid <= 1'b1;
        if (state == S_RD_WAIT) begin
          out_we   <= 1'b1;
          out_data <= align_data;
        end
      end
    end
  end

  // Line buffer. Fill is ordered after flush so a completing read leaves it valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= '0;
    end else begin
      if (flush) buf_valid <= 1'b0;
      if (fill) begin
        buf_valid <= 1'b1;
        buf_tag   <= lat_addr[WORDSZ-1:BLK_OFF_BITS];
        buf_data  <= mem_data_in;
      end
      // Write-through store into a buffered block keeps the buffer coherent.
      if (accept && in_is_store && !acc_err && buf_hit) begin
        for (int i = 0; i < 8; i++) begin
          if (st_strb[i])
            buf_data[{in_addr[5:3], 6'b000000} + i*8 +: 8] <= st_wdata[i*8 +: 8];
        end
      end
    end
  end

endmodule
